// File: rtl/fp_pkg.sv
// fp_pkg: shared rounding-mode encodings, status flag bit indices and default widths
package fp_pkg;
  localparam int WEXP_DEF = 8;
  localparam int WSIG_DEF = 24;
  typedef enum logic [1:0] {RM_RNE = 2'd0, RM_RZ = 2'd1, RM_RUP = 2'd2, RM_RDN = 2'd3} rm_e;
  localparam int F_OVF = 3;
  localparam int F_UNF = 2;
  localparam int F_INV = 1;
  localparam int F_INX = 0;
endpackage

// File: rtl/fp_skid_buf.sv
// fp_skid_buf: 2-entry registered skid buffer; in_ready is a flop, output register feeds out_data
module fp_skid_buf #(
  parameter int W = 36
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
  logic acc, ld;
  logic [W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  // output slot refills from skid first, else straight from the input; skid catches input while output stalls
  always_comb begin
    acc = in_valid & in_ready_q;
    ld = ~out_valid_q | out_ready;
    out_valid_d = ld ? (skid_valid_q | acc) : 1'b1;
    out_data_d = ld ? (skid_valid_q ? skid_data_q : (acc ? in_data : out_data_q)) : out_data_q;
    skid_valid_d = ~ld & (skid_valid_q | acc);
    skid_data_d = (~ld & acc) ? in_data : skid_data_q;
    in_ready_d = ~skid_valid_d;
  end
  // state update; reset empties both slots and holds in_ready low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q <= skid_data_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
endmodule

// File: rtl/fp_final_stage.sv
// fp_final_stage: FP adder result packing, special cases and IEEE flags; FPF_DIRECTED_RM_EN enables directed rounding
module fp_final_stage
  import fp_pkg::*;
#(
  parameter int WEXP = WEXP_DEF,
  parameter int WSIG = WSIG_DEF
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WSIG-2:0]      a_frac,
  input  logic [WSIG-2:0]      b_frac,
  input  logic                 sa,
  input  logic                 sb,
  input  logic                 abig,
  input  logic                 ainf,
  input  logic                 binf,
  input  logic                 anan,
  input  logic                 bnan,
  input  logic                 asnan,
  input  logic                 bsnan,
  input  logic                 denorm,
  input  logic                 inex,
  input  logic                 expneg,
  input  logic                 effop,
  input  logic                 op,
  input  logic                 zero,
  input  logic [WEXP:0]        exp,
  input  logic [WSIG-2:0]      roundsum,
  input  logic [1:0]           rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WEXP+WSIG-1:0] result,
  output logic [3:0]           out_flags,
  input  logic                 flag_clr,
  output logic [3:0]           sticky_flags
);
  localparam int W = WEXP + WSIG;
  logic specinput, ovf, unf, inv, inx, nsign, zsign, sign, maxfin;
  logic [WSIG-2:0] nan_frac;
  logic [W-1:0] res;
  logic [3:0] flags, sticky_d, sticky_q;
  logic [W+3:0] out_pl;
  logic unused_bits;
`ifdef FPF_DIRECTED_RM_EN
  assign unused_bits = ^{a_frac[WSIG-2], b_frac[WSIG-2]};
`else
  assign unused_bits = ^{a_frac[WSIG-2], b_frac[WSIG-2], rm};
`endif
  // classify the operation, pick the signs and select NaN / zero / max-finite / infinity / normal result
  always_comb begin
    specinput = ainf | binf | anan | bnan;
    ovf = (exp[WEXP] | &exp[WEXP-1:0]) & ~expneg & ~specinput & ~zero;
    unf = expneg & inex;
    inv = (ainf & binf & effop) | asnan | bsnan;
    inx = (inex | ovf) & ~specinput;
    flags = '0;
    flags[F_OVF] = ovf;
    flags[F_UNF] = unf;
    flags[F_INV] = inv;
    flags[F_INX] = inx;
    nsign = (abig & sa) | ((sb ^ op) & (~abig | sa));
`ifdef FPF_DIRECTED_RM_EN
    maxfin = ovf & ((rm == RM_RZ) | ((rm == RM_RUP) & nsign) | ((rm == RM_RDN) & ~nsign));
    zsign = (sa & (sb ^ op)) | ((sa ^ (sb ^ op)) & (rm == RM_RDN));
`else
    maxfin = 1'b0;
    zsign = sa & (sb ^ op);
`endif
    sign = zero ? zsign : nsign;
    nan_frac = {1'b1, anan ? a_frac[WSIG-3:0] : (bnan ? b_frac[WSIG-3:0] : {(WSIG-2){1'b0}})};
    res = (anan | bnan | inv) ? {sign, {WEXP{1'b1}}, nan_frac}
        : (unf | zero | denorm) ? {sign, {(W-1){1'b0}}}
        : maxfin ? {sign, {(WEXP-1){1'b1}}, 1'b0, {(WSIG-1){1'b1}}}
        : (specinput | ovf) ? {sign, {WEXP{1'b1}}, {(WSIG-1){1'b0}}}
        : {sign, exp[WEXP-1:0], roundsum};
    sticky_d = (flag_clr ? 4'b0 : sticky_q) | ((in_valid & in_ready) ? flags : 4'b0);
  end
  // accumulated status flags
  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= '0;
    else sticky_q <= sticky_d;
  end
  fp_skid_buf #(.W(W + 4)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data({flags, res}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_pl)
  );
  assign result = out_pl[W-1:0];
  assign out_flags = out_pl[W+3:W];
  assign sticky_flags = sticky_q;
endmodule

// File: tb/tb_fp_final_stage.sv
// tb_fp_final_stage: directed checks of fp_final_stage result packing, flags, buffering and reset
module tb_fp_final_stage;
  import fp_pkg::*;
  localparam int WEXP = 8;
  localparam int WSIG = 24;
`ifdef FPF_DIRECTED_RM_EN
  localparam logic [31:0] OVF_RZ = 32'h7F7FFFFF;
`else
  localparam logic [31:0] OVF_RZ = 32'h7F800000;
`endif
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, flag_clr;
  logic sa, sb, abig, ainf, binf, anan, bnan, asnan, bsnan, denorm, inex, expneg, effop, op, zero;
  logic [WSIG-2:0] a_frac, b_frac, roundsum;
  logic [WEXP:0] ex;
  logic [1:0] rm;
  logic [31:0] result;
  logic [3:0] out_flags, sticky_flags;
  int checks = 0;
  int fails = 0;
  logic [31:0] bp_exp [4];
  int sent, got;
  logic acc_now, pop_now;

  always #5 clk = ~clk;

  fp_final_stage #(.WEXP(WEXP), .WSIG(WSIG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_frac(a_frac), .b_frac(b_frac), .sa(sa), .sb(sb), .abig(abig),
    .ainf(ainf), .binf(binf), .anan(anan), .bnan(bnan), .asnan(asnan), .bsnan(bsnan),
    .denorm(denorm), .inex(inex), .expneg(expneg), .effop(effop), .op(op), .zero(zero),
    .exp(ex), .roundsum(roundsum), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_flags(out_flags), .flag_clr(flag_clr), .sticky_flags(sticky_flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {sa, sb, abig, ainf, binf, anan, bnan, asnan, bsnan, denorm, inex, expneg, effop, op, zero} = '0;
    a_frac = '0;
    b_frac = '0;
    roundsum = '0;
    ex = '0;
    rm = 2'(RM_RNE);
    flag_clr = 1'b0;
  endtask

  task automatic send;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle;
    tick;
    tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result", result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_sticky", sticky_flags, 0);
    rst_n = 1'b1;
    tick;
    chk("post_rst_in_ready", in_ready, 1);

    ex = 9'h07F; roundsum = 23'h400000; abig = 1'b1;
    send;
    chk("normal_valid", out_valid, 1);
    chk("normal_result", result, 32'h3FC00000);
    chk("normal_flags", out_flags, 4'b0000);

    idle;
    ex = 9'h0FF; rm = 2'(RM_RZ); abig = 1'b1;
    send;
    chk("ovf_result", result, OVF_RZ);
    chk("ovf_flags", out_flags, 4'b1001);
    chk("ovf_sticky", sticky_flags, 4'b1001);

    idle;
    ex = 9'h07F; roundsum = 23'h400000; abig = 1'b1; inex = 1'b1; flag_clr = 1'b1;
    send;
    flag_clr = 1'b0;
    chk("clr_sticky", sticky_flags, 4'b0001);
    chk("clr_flags", out_flags, 4'b0001);
    chk("clr_result", result, 32'h3FC00000);

    idle;
    ex = 9'h07F; ainf = 1'b1; binf = 1'b1; effop = 1'b1;
    send;
    chk("inv_result", result, 32'h7FC00000);
    chk("inv_flags", out_flags, 4'b0010);
    chk("inv_sticky", sticky_flags, 4'b0011);

    idle;
    anan = 1'b1; asnan = 1'b1; a_frac = 23'h000001;
    send;
    chk("snan_result", result, 32'h7FC00001);
    chk("snan_flags", out_flags, 4'b0010);

    idle;
    zero = 1'b1; sa = 1'b1; op = 1'b1;
    send;
    chk("zero_result", result, 32'h80000000);
    chk("zero_flags", out_flags, 4'b0000);

    idle;
    expneg = 1'b1; inex = 1'b1; ex = 9'h001;
    send;
    chk("unf_result", result, 32'h00000000);
    chk("unf_flags", out_flags, 4'b0101);

    idle;
    tick;
    bp_exp = '{32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000};
    sent = 0;
    got = 0;
    abig = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      out_ready = (c >= 3);
      in_valid = (sent < 4);
      ex = 9'h080 + 9'(sent);
      acc_now = in_valid & in_ready;
      pop_now = out_valid & out_ready;
      if (pop_now) begin
        chk("bp_order", result, bp_exp[got]);
        got++;
      end
      if (c == 2) begin
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_hold", result, 32'h40000000);
      end
      tick;
      if (acc_now) sent++;
    end
    in_valid = 1'b0;
    chk("bp_count", got, 4);

    idle;
    out_ready = 1'b0;
    ex = 9'h07F; inex = 1'b1;
    send;
    send;
    rst_n = 1'b0;
    tick;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sticky", sticky_flags, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    tick;
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/fp_final_stage.md
FP_FINAL_STAGE -- requirements
Module: fp_final_stage

Interface
REQ-001 SHALL have parameter WEXP, default 8, exponent field width.
REQ-002 SHALL have parameter WSIG, default 24, significand width incl. hidden bit; stored fraction = WSIG-1 bits.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1; upstream handshake, transfer when both high.
REQ-006 SHALL have ports a_frac, b_frac  in  WSIG-1  operand fractions (NaN payload source).
REQ-007 SHALL have ports sa, sb, abig, ainf, binf, anan, bnan, asnan, bsnan, denorm, inex, expneg, effop, op, zero  in  1 each  operand/datapath flags, meanings as the existing adder path.
REQ-008 SHALL have port exp  in  WEXP+1  computed exponent, MSB = overflow carry.
REQ-009 SHALL have port roundsum  in  WSIG-1  rounded fraction.
REQ-010 SHALL have port rm  in  2  rounding mode (RNE=0, RZ=1, RUP=2, RDN=3); ignored without FPF_DIRECTED_RM_EN.
REQ-011 SHALL have ports out_valid out 1, out_ready in 1; downstream handshake.
REQ-012 SHALL have port result  out  WEXP+WSIG  {sign, exponent, fraction}.
REQ-013 SHALL have port out_flags  out  4  {overflow, underflow, invalid, inexact} of current result.
REQ-014 SHALL have ports flag_clr in 1, sticky_flags out 4; accumulated IEEE status.

Function
REQ-015 SHALL derive specinput = ainf|binf|anan|bnan; overflow = (exp[WEXP] | &exp[WEXP-1:0]) & ~expneg & ~specinput & ~zero; underflow = expneg & inex; invalid = (ainf&binf&effop)|asnan|bsnan; inexact = (inex|overflow) & ~specinput.
REQ-016 SHALL produce NaN (exp all-ones, fraction = {1, payload[WSIG-3:0]} from a_frac if anan else b_frac) when anan|bnan|invalid; payload zero when neither input is NaN.
REQ-017 SHALL produce signed zero (exp 0, fraction 0) for underflow|zero|denorm when not invalid; infinity for other specinput or overflow cases; else {exp[WEXP-1:0], roundsum}.
REQ-018 SHALL compute non-zero sign = (abig&sa) | ((sb^op) & (~abig|sa)); zero sign = sa & (sb^op).
REQ-019 SHALL register outputs: latency exactly 1 cycle from accepted input to out_valid; sustained throughput 1 result/cycle.
REQ-020 SHALL buffer 2 entries; in_ready high whenever at least one entry free (registered, no combinational out_ready->in_ready path).
REQ-021 SHALL hold result/out_flags stable while out_valid & ~out_ready; results leave in input order, none dropped or duplicated.
REQ-022 SHALL OR out_flags of each accepted input into sticky_flags the cycle after acceptance.
REQ-023 SHALL, on flag_clr with simultaneous accept, clear old sticky bits and load only the new input's flags.

Reset
REQ-024 SHALL, with rst_n low at clk edge, empty buffer, drive out_valid=0, in_ready=0 during reset then 1 the cycle after release, result=0, out_flags=0, sticky_flags=0.
REQ-025 SHALL discard in-flight results on reset mid-operation; no output after release until new input.

Configuration
REQ-026 SHALL gate directed-rounding support with macro FPF_DIRECTED_RM_EN.
REQ-027 SHALL, with FPF_DIRECTED_RM_EN defined, output max finite (exp all-ones-1, fraction all-ones) on overflow when rm=RZ, rm=RUP & sign=1, or rm=RDN & sign=0; exact-zero sign = (sa&(sb^op)) | ((sa^(sb^op)) & rm==RDN).
REQ-028 SHALL, without FPF_DIRECTED_RM_EN, always return infinity on overflow and use REQ-018 zero sign; rm unused.

Structure
REQ-029 SHALL take rm encodings, flag bit indices, default widths from shared package fp_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module fp_skid_buf, parametrised in payload width.

Verification
REQ-031 SHALL check normal: WEXP=8/WSIG=24, exp=0x7F, roundsum=0x400000, sa=sb=0, abig=1 -> result 0x3FC00000, flags 0, 1 cycle later.
REQ-032 SHALL check overflow: exp=0x0FF, rm=RZ, sign 0 -> 0x7F7FFFFF with macro, 0x7F800000 without; flags overflow|inexact; sticky set.
REQ-033 SHALL check invalid: ainf=binf=effop=1 -> 0x7FC00000, invalid=1; asnan with a_frac=0x000001 -> fraction 0x400001.
REQ-034 SHALL check backpressure: 4 back-to-back inputs, out_ready low 3 cycles -> in_ready low after 2 accepted, all 4 outputs in order, no loss.
REQ-035 SHALL check flag_clr with simultaneous inexact accept -> sticky_flags = 0001 next cycle; rst_n low mid-stream -> out_valid 0, sticky 0.
